// File: rtl/fetch_seq_von_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_von_if
// Brief    : Bus bundle between the fetch sequencer and its surroundings
//            (program counter control, shared memory read port, decoder
//            hand-off and status).
// Revision : 1.0  initial release
// ============================================================================
interface fetch_seq_von_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] pc_value;
    logic          pc_load;
    logic          pc_inc;
    logic          pc_clear;
    logic [AW-1:0] pc_data;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] ir;
    logic          ir_valid;
    logic          ir_ack;
    logic          jump_req;
    logic [AW-1:0] jump_addr;
    logic          halt;
    logic          halted;
    logic          fault;
    logic [15:0]   fetch_cnt;

    // Sequencer side
    modport master (
        input  pc_value, mem_ready, mem_rdata, ir_ack, jump_req, jump_addr, halt,
        output pc_load, pc_inc, pc_clear, pc_data, mem_rd, mem_addr,
               ir, ir_valid, halted, fault, fetch_cnt
    );

    // PC / memory / decoder side
    modport slave (
        output pc_value, mem_ready, mem_rdata, ir_ack, jump_req, jump_addr, halt,
        input  pc_load, pc_inc, pc_clear, pc_data, mem_rd, mem_addr,
               ir, ir_valid, halted, fault, fetch_cnt
    );
endinterface : fetch_seq_von_if
`default_nettype wire

// File: rtl/fetch_seq_von.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_von
// Brief    : Instruction-fetch sequencer for the von Neumann core. Clears the
//            PC, reads memory at the PC, latches the word into ir, hands it
//            to the decoder and applies decoder-requested jumps.
//            Optional macro FETCH_TIMEOUT_EN adds a mem_ready timeout that
//            parks the sequencer in a fault state.
// Revision : 1.0  initial release
// ============================================================================
module fetch_seq_von #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int TO_CYCLES = 16
) (
    input  wire logic         clk,
    input  wire logic         clear,
    fetch_seq_von_if.master   bus
);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_FETCH = 3'd1,
        S_HOLD  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [DW-1:0] r_ir;
    logic [15:0]   r_fetch_cnt;
    logic          w_fetch_done;

    // A fetch completes only when memory answers while we are asking
    assign w_fetch_done = (r_state == S_FETCH) && bus.mem_ready;

`ifdef FETCH_TIMEOUT_EN
    localparam int c_to_w = $clog2(TO_CYCLES + 1);
    logic [c_to_w-1:0] r_to_cnt;
    logic              w_to_expire;

    // Counts consecutive unanswered fetch cycles; zero whenever not fetching
    always_ff @(posedge clk) begin
        if (clear) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_FETCH) && !bus.mem_ready) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    // This unanswered cycle is the TO_CYCLES-th one: give up after it
    assign w_to_expire = (r_to_cnt == c_to_w'(TO_CYCLES - 1));
    assign bus.fault   = !clear && (r_state == S_FAULT);
`else
    logic [31:0] w_unused_to;
    assign w_unused_to = TO_CYCLES;
    assign bus.fault   = 1'b0;
`endif

    // State, instruction register and fetch counter; clear wins over a late mem_ready
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state     <= S_START;
            r_ir        <= '0;
            r_fetch_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fetch_done) begin
                r_ir        <= bus.mem_rdata;
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
        end
    end

    assign bus.ir        = r_ir;
    assign bus.fetch_cnt = r_fetch_cnt;

    // Next state and per-cycle strobes; everything is quiet while clear is high
    always_comb begin
        w_state_next = r_state;
        bus.pc_load  = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.pc_clear = 1'b0;
        bus.pc_data  = '0;
        bus.mem_rd   = 1'b0;
        bus.mem_addr = '0;
        bus.ir_valid = 1'b0;
        bus.halted   = 1'b0;
        if (!clear) begin
            case (r_state)
                S_START: begin
                    bus.pc_clear = 1'b1;
                    w_state_next = S_FETCH;
                end
                S_FETCH: begin
                    bus.mem_rd   = 1'b1;
                    bus.mem_addr = bus.pc_value;
                    if (bus.mem_ready) begin
                        bus.pc_inc   = 1'b1;
                        w_state_next = S_HOLD;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (w_to_expire) begin
                        w_state_next = S_FAULT;
                    end
`endif
                end
                S_HOLD: begin
                    bus.ir_valid = 1'b1;
                    if (bus.halt) begin
                        w_state_next = S_HALT;
                    end else if (bus.ir_ack) begin
                        if (bus.jump_req) begin
                            bus.pc_load = 1'b1;
                            bus.pc_data = bus.jump_addr;
                        end
                        w_state_next = S_FETCH;
                    end
                end
                S_HALT: begin
                    bus.halted = 1'b1;
                end
                S_FAULT: begin
                    bus.halted = 1'b1;
                end
                default: begin
                    w_state_next = S_START;
                end
            endcase
        end
    end

endmodule : fetch_seq_von
`default_nettype wire

// File: tb/tb_fetch_seq_von.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_seq_von
// Brief    : Directed self-checking bench for fetch_seq_von with a small PC
//            model and a memory returning 0xA0 + address.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_seq_von;

    logic clk   = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    fetch_seq_von_if #(.AW(8), .DW(8)) bus ();

    fetch_seq_von #(.AW(8), .DW(8), .TO_CYCLES(16)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    // Program counter model reacting to the strobes; pc_set lets the bench preload it
    logic [7:0] pc         = 8'h00;
    logic       pc_set_en  = 1'b0;
    logic [7:0] pc_set_val = 8'h00;
    always @(posedge clk) begin
        if (pc_set_en)         pc <= pc_set_val;
        else if (bus.pc_clear) pc <= 8'h00;
        else if (bus.pc_load)  pc <= bus.pc_data;
        else if (bus.pc_inc)   pc <= pc + 8'h01;
    end
    assign bus.pc_value = pc;

    // Memory: zero-wait when auto_ready, otherwise mem_ready driven directly
    logic auto_ready = 1'b1;
    logic man_ready  = 1'b0;
    assign bus.mem_ready = auto_ready ? bus.mem_rd : man_ready;
    assign bus.mem_rdata = 8'hA0 + bus.mem_addr;

    int pc_clear_cnt = 0;
    always @(posedge clk) if (bus.pc_clear) pc_clear_cnt <= pc_clear_cnt + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    initial begin
        bus.ir_ack    = 1'b1;
        bus.jump_req  = 1'b0;
        bus.jump_addr = 8'h00;
        bus.halt      = 1'b0;

        // Reset state
        nx(); nx(); #1;
        chk("rst_ir", bus.ir, 0);
        chk("rst_cnt", bus.fetch_cnt, 0);
        chk("rst_strobes", {bus.pc_load, bus.pc_inc, bus.pc_clear}, 0);
        chk("rst_memrd", bus.mem_rd, 0);
        chk("rst_flags", {bus.ir_valid, bus.halted, bus.fault}, 0);
        chk("rst_pcdata", bus.pc_data, 0);
        chk("rst_memaddr", bus.mem_addr, 0);

        // Release clear: one pc_clear then zero-wait fetches with immediate ack
        nx(); clear = 1'b0; #1;
        chk("start_pc_clear", bus.pc_clear, 1);
        chk("start_memrd", bus.mem_rd, 0);
        for (int i = 0; i < 3; i++) begin
            nx(); #1;
            chk("seq_memrd", bus.mem_rd, 1);
            chk("seq_addr", bus.mem_addr, i);
            chk("seq_inc", bus.pc_inc, 1);
            nx(); if (i == 2) bus.ir_ack = 1'b0; #1;
            chk("seq_ir", bus.ir, 8'hA0 + i);
            chk("seq_valid", bus.ir_valid, 1);
        end
        chk("seq_cnt", bus.fetch_cnt, 3);
        chk("pc_clear_once", pc_clear_cnt, 1);

        // Three wait states at address 0x05
        pc_set_en = 1'b1; pc_set_val = 8'h05; bus.ir_ack = 1'b1;
        auto_ready = 1'b0; man_ready = 1'b0;
        for (int w = 0; w < 4; w++) begin
            nx(); pc_set_en = 1'b0; bus.ir_ack = 1'b0; man_ready = (w == 3); #1;
            chk("ws_memrd", bus.mem_rd, 1);
            chk("ws_addr", bus.mem_addr, 8'h05);
            chk("ws_inc", bus.pc_inc, (w == 3));
        end
        nx(); man_ready = 1'b0; #1;
        chk("ws_ir", bus.ir, 8'hA5);
        chk("ws_cnt", bus.fetch_cnt, 4);
        chk("hold_memrd", bus.mem_rd, 0);

        // Decoder stalls five cycles, then acks with a jump to 0x40
        for (int h = 0; h < 4; h++) begin
            nx(); #1;
            chk("stall_ir", bus.ir, 8'hA5);
            chk("stall_valid", bus.ir_valid, 1);
            chk("stall_load", bus.pc_load, 0);
        end
        nx(); bus.ir_ack = 1'b1; bus.jump_req = 1'b1; bus.jump_addr = 8'h40; #1;
        chk("jmp_load", bus.pc_load, 1);
        chk("jmp_data", bus.pc_data, 8'h40);
        chk("jmp_inc", bus.pc_inc, 0);
        nx(); bus.ir_ack = 1'b0; bus.jump_req = 1'b0; bus.jump_addr = 8'h55; man_ready = 1'b1; #1;
        chk("jmp_load_off", bus.pc_load, 0);
        chk("jmp_data_off", bus.pc_data, 0);
        chk("jmp_addr", bus.mem_addr, 8'h40);
        nx(); #1;
        chk("jmp_ir", bus.ir, 8'hE0);

        // Fetch at 0xFF wraps to 0x00
        pc_set_en = 1'b1; pc_set_val = 8'hFF; bus.ir_ack = 1'b1;
        nx(); pc_set_en = 1'b0; #1;
        chk("wrap_addr", bus.mem_addr, 8'hFF);
        chk("wrap_inc", bus.pc_inc, 1);
        chk("wrap_fault", bus.fault, 0);
        nx(); #1;
        chk("wrap_ir", bus.ir, 8'h9F);
        nx(); #1;
        chk("wrap_next_addr", bus.mem_addr, 8'h00);

        // halt together with ack: no strobe, instruction not consumed
        nx(); bus.halt = 1'b1; #1;
        chk("halt_ir", bus.ir, 8'hA0);
        chk("halt_strobes", {bus.pc_load, bus.pc_inc, bus.pc_clear}, 0);
        nx(); bus.halt = 1'b0; #1;
        chk("halted", bus.halted, 1);
        chk("halt_valid", bus.ir_valid, 0);
        for (int k = 0; k < 3; k++) begin
            nx(); #1;
            chk("halt_memrd", bus.mem_rd, 0);
        end
        chk("halt_cnt", bus.fetch_cnt, 7);

        // Clear out of halt, then clear again mid-fetch with a late mem_ready
        nx(); clear = 1'b1; man_ready = 1'b0; #1;
        chk("clr_halted", bus.halted, 0);
        nx(); #1;
        chk("clr_ir", bus.ir, 0);
        clear = 1'b0; #1;
        chk("clr_pc_clear", bus.pc_clear, 1);
        nx(); #1;
        chk("mid_memrd", bus.mem_rd, 1);
        chk("mid_inc", bus.pc_inc, 0);
        nx(); clear = 1'b1; man_ready = 1'b1; #1;
        chk("late_inc", bus.pc_inc, 0);
        chk("late_memrd", bus.mem_rd, 0);
        nx(); man_ready = 1'b0; #1;
        chk("late_ir", bus.ir, 0);
        chk("late_cnt", bus.fetch_cnt, 0);
        clear = 1'b0; #1;
        chk("late_restart", bus.pc_clear, 1);

`ifdef FETCH_TIMEOUT_EN
        // mem_ready in the 16th wait cycle still completes
        for (int k = 1; k <= 16; k++) begin
            nx(); man_ready = (k == 16); #1;
            chk("to_edge_fault", bus.fault, 0);
            chk("to_edge_inc", bus.pc_inc, (k == 16));
        end
        nx(); man_ready = 1'b0; #1;
        chk("to_edge_ir", bus.ir, 8'hA0);
        // Memory never answers: fault after 16 wait cycles
        for (int k = 1; k <= 16; k++) begin
            nx(); #1;
            chk("to_wait_memrd", bus.mem_rd, 1);
            chk("to_wait_fault", bus.fault, 0);
        end
        nx(); #1;
        chk("to_fault", bus.fault, 1);
        chk("to_halted", bus.halted, 1);
        chk("to_memrd", bus.mem_rd, 0);
`else
        // Without the timeout a long wait never faults
        for (int k = 1; k <= 20; k++) begin
            nx(); #1;
            chk("wait_memrd", bus.mem_rd, 1);
            chk("wait_fault", bus.fault, 0);
        end
        nx(); man_ready = 1'b1; #1;
        chk("wait_inc", bus.pc_inc, 1);
        nx(); man_ready = 1'b0; #1;
        chk("wait_ir", bus.ir, 8'hA0);
        chk("wait_halted", bus.halted, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_fetch_seq_von
`default_nettype wire

// File: doc/fetch_seq_von.md
Name: fetch_seq_von

Overview:
- Instruction-fetch sequencer for the von Neumann core.
- Drives the control side of the 8-bit program counter: load, inc, clear and jump target.
- Reads the PC value, issues a read to the shared memory with a ready handshake, latches the returned word into the instruction register, and hands it to the decoder with a valid/ack handshake.
- Applies jumps requested by the decoder; halts on request.

Parameters:
- AW, 8, width of PC, memory address and jump target.
- DW, 8, width of memory read data and instruction register.
- TO_CYCLES, 16, maximum cycles waiting for mem_ready before a fetch fault. Used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clear  in  1  synchronous active-high reset.
- pc_value  in  AW  current program counter value.
- pc_load  out  1  PC load strobe; PC takes pc_data.
- pc_inc  out  1  PC increment strobe.
- pc_clear  out  1  PC clear strobe.
- pc_data  out  AW  jump target presented to the PC.
- mem_rd  out  1  memory read request.
- mem_addr  out  AW  read address.
- mem_ready  in  1  read data valid this cycle.
- mem_rdata  in  DW  read data.
- ir  out  DW  instruction register.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ack  in  1  decoder accepts ir.
- jump_req  in  1  redirect PC; sampled with ir_ack.
- jump_addr  in  AW  jump target.
- halt  in  1  stop fetching.
- halted  out  1  sequencer is in S_HALT.
- fault  out  1  fetch timeout; always 0 when the option is disabled.
- fetch_cnt  out  16  completed fetches, wraps.

Behaviour:
- Reset:
  - While clear=1: state=S_START.
  - ir=0, fetch_cnt=0, timeout counter=0.
  - All strobes, mem_rd, ir_valid, halted and fault are 0; pc_data=0, mem_addr=0.
  - Reset takes priority over everything, including mid-fetch: an outstanding read is abandoned and a late mem_ready is ignored.
- At most one of pc_load/pc_inc/pc_clear is asserted per cycle. All three are combinational from state and inputs, one cycle wide.
- S_START: pc_clear=1 for exactly one cycle -> S_FETCH.
- S_FETCH:
  - mem_rd=1, mem_addr=pc_value.
  - If mem_ready=1 in the same cycle: ir<=mem_rdata, pc_inc=1, fetch_cnt<=fetch_cnt+1 (wraps 0xFFFF->0) -> S_HOLD.
  - Otherwise stay in S_FETCH.
  - Fetch latency: 1 cycle minimum (mem_ready in the first S_FETCH cycle).
- S_HOLD:
  - ir_valid=1, mem_rd=0. pc_value is already the incremented value.
  - halt=1: -> S_HALT with no PC strobe, even if ir_ack=1 in the same cycle; the instruction is not consumed.
  - Else ir_ack=1 and jump_req=1: pc_load=1, pc_data=jump_addr -> S_FETCH. The next fetch reads jump_addr.
  - Else ir_ack=1: -> S_FETCH.
  - Else stay in S_HOLD; ir is held stable.
- S_HALT: halted=1, ir_valid=0, no strobes, no reads. Exit only via clear.
- mem_ready outside S_FETCH is ignored. ir_ack and jump_req outside S_HOLD are ignored.
- pc_data=jump_addr only in a pc_load cycle, otherwise 0.
- mem_addr=0 outside S_FETCH.
- PC wrap-around: increment 0xFF->0x00 is the PC's responsibility; the sequencer fetches from 0x00 next with no special case.
- Back-to-back throughput: 2 cycles per instruction (S_FETCH, S_HOLD) with zero-wait memory and immediate ack.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter increments each S_FETCH cycle without mem_ready and resets on entry to S_FETCH.
  - When it reaches TO_CYCLES with mem_ready still 0: -> S_FAULT, with fault=1 and halted=1, no strobes, mem_rd=0. Exit only via clear.
  - mem_ready in the TO_CYCLES-th wait cycle still completes the fetch normally.
- Undefined: no counter; S_FETCH waits indefinitely and fault is tied 0.

Test Plan:
- Release clear with zero-wait memory returning mem[n]=0xA0+n and ir_ack always 1:
  - pc_clear pulses exactly once.
  - ir sequence is 0xA0, 0xA1, 0xA2, one new value every 2 cycles.
  - fetch_cnt=3 after the third fetch.
- Memory with 3 wait states at pc_value=0x05:
  - mem_rd high 4 cycles with mem_addr=0x05.
  - pc_inc is high only in the cycle mem_ready=1.
  - ir=mem_rdata.
- In S_HOLD hold ir_ack=0 for 5 cycles, then ack with jump_req=1, jump_addr=0x40:
  - ir stable and ir_valid=1 throughout the wait.
  - One-cycle pc_load with pc_data=0x40.
  - Next mem_addr=0x40.
- pc_value=0xFF fetch: pc_inc asserted, next fetch address 0x00, no fault.
- In S_HOLD assert halt=1 and ir_ack=1 together:
  - No PC strobe, halted=1, ir_valid=0.
  - mem_rd stays 0 until clear.
  - Clear mid-S_FETCH with a late mem_ready returns to S_START with ir=0.
- With FETCH_TIMEOUT_EN defined and TO_CYCLES=16, mem_ready never asserted: fault=1 after 16 wait cycles.
- Repeat with mem_ready in wait cycle 16: normal fetch, fault stays 0.
